// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i core: opcodes, funct codes, FSM states,
// ALU operations and memory access sizes.
package rv32i_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [2:0] {
      S_FETCH, S_EXECUTE, S_MEM, S_WRITE, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   // Matches funct3[1:0] of loads and stores; funct3[2] selects zero extension.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10
   } mem_size_t;

endpackage

// File: rtl/rv32i_if.sv
// Shared instruction/data memory port between the core (master) and memory (slave).
interface rv32i_if;
   logic [31:2] address;
   logic [31:0] memory_in;
   logic        write_enable;
   logic [31:0] memory_out;
   logic        read_capable;
   logic        write_capable;

   modport master (
      output address, memory_in, write_enable,
      input  memory_out, read_capable, write_capable
   );

   modport slave (
      input  address, memory_in, write_enable,
      output memory_out, read_capable, write_capable
   );
endinterface

// File: rtl/rv32i_alu.sv
// Combinational RV32I ALU with compare flags for branch resolution.
module rv32i_alu
   import rv32i_pkg::*;
(
   input  alu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        eq,
   output logic        lt,
   output logic        ltu
);

   assign eq  = (a == b);
   assign lt  = ($signed(a) < $signed(b));
   assign ltu = (a < b);

   always_comb begin
      result = '0;
      unique case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << b[4:0];
         ALU_SLT:  result = {31'd0, lt};
         ALU_SLTU: result = {31'd0, ltu};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> b[4:0];
         ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_core.sv
// Multicycle RV32I core on a single shared word-addressed memory port.
// FETCH -> EXECUTE -> (MEM -> (WRITE)) -> FETCH; any fault parks in HALT.
module rv32i_core
   import rv32i_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   rv32i_if.master bus
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, ea_q, ea_d, mdr_q, mdr_d;
   logic [31:2] addr_q;
   logic [31:0] regs [32];
   logic        rd_we;
   logic [31:0] rd_wdata;

   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val, alu_b, alu_result;
   logic [31:0] pc_plus4, br_target, jal_target, ea_sum, jalr_target;
   logic [31:0] ld_shift, ld_data, st_mask, st_merged;
   logic [4:0]  byte_shift;
   logic        alu_eq, alu_lt, alu_ltu;
   logic        arith_ok, br_legal, br_taken, ld_legal, st_legal, misaligned;
   alu_op_t     alu_op;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign funct7 = ir_q[31:25];

   assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_u = {ir_q[31:12], 12'd0};
   assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

   assign rs1_val     = regs[rs1];
   assign rs2_val     = regs[rs2];
   assign alu_b       = (opcode == OP_IMM) ? imm_i : rs2_val;
   assign pc_plus4    = pc_q + 32'd4;
   assign br_target   = pc_q + imm_b;
   assign jal_target  = pc_q + imm_j;
   assign ea_sum      = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
   assign jalr_target = {ea_sum[31:1], 1'b0};

   rv32i_alu u_alu (
      .op     (alu_op),
      .a      (rs1_val),
      .b      (alu_b),
      .result (alu_result),
      .eq     (alu_eq),
      .lt     (alu_lt),
      .ltu    (alu_ltu)
   );

   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         F3_ADD:  alu_op = (opcode == OP_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
         F3_SLL:  alu_op = ALU_SLL;
         F3_SLT:  alu_op = ALU_SLT;
         F3_SLTU: alu_op = ALU_SLTU;
         F3_XOR:  alu_op = ALU_XOR;
         F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
         F3_OR:   alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   end

   // OP-IMM only constrains funct7 on shifts; elsewhere those bits are immediate.
   always_comb begin
      arith_ok = 1'b1;
      if (opcode == OP_OP)
         arith_ok = (funct7 == F7_BASE) ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
      else if (funct3 == F3_SLL)
         arith_ok = (funct7 == F7_BASE);
      else if (funct3 == F3_SR)
         arith_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
   end

   always_comb begin
      br_legal = 1'b1;
      br_taken = 1'b0;
      case (funct3)
         F3_BEQ:  br_taken = alu_eq;
         F3_BNE:  br_taken = !alu_eq;
         F3_BLT:  br_taken = alu_lt;
         F3_BGE:  br_taken = !alu_lt;
         F3_BLTU: br_taken = alu_ltu;
         F3_BGEU: br_taken = !alu_ltu;
         default: br_legal = 1'b0;
      endcase
   end

   assign ld_legal   = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
   assign st_legal   = !funct3[2] && (funct3[1:0] != 2'b11);
   assign misaligned = (funct3[1:0] == SZ_HALF && ea_q[0]) ||
                       (funct3[1:0] == SZ_WORD && ea_q[1:0] != 2'b00);

   assign byte_shift = {ea_q[1:0], 3'b000};
   assign ld_shift   = bus.memory_out >> byte_shift;
   assign st_mask    = ((funct3[1:0] == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << byte_shift;
   assign st_merged  = (mdr_q & ~st_mask) | ((rs2_val << byte_shift) & st_mask);

   always_comb begin
      ld_data = bus.memory_out;
      if (funct3[1:0] == SZ_BYTE)
         ld_data = {{24{!funct3[2] && ld_shift[7]}}, ld_shift[7:0]};
      else if (funct3[1:0] == SZ_HALF)
         ld_data = {{16{!funct3[2] && ld_shift[15]}}, ld_shift[15:0]};
   end

   always_comb begin
      state_d           = state_q;
      pc_d              = pc_q;
      ir_d              = ir_q;
      ea_d              = ea_q;
      mdr_d             = mdr_q;
      rd_we             = 1'b0;
      rd_wdata          = '0;
      bus.address       = pc_q[31:2];
      bus.memory_in     = '0;
      bus.write_enable  = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (!bus.read_capable || pc_q[1:0] != 2'b00) begin
               state_d = S_HALT;
            end else begin
               ir_d    = bus.memory_out;
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            state_d = S_FETCH;
            pc_d    = pc_plus4;
            case (opcode)
               OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
               OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
               OP_JAL: begin
                  if (jal_target[1]) state_d = S_HALT;
                  else begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_d = jal_target; end
               end
               OP_JALR: begin
                  if (funct3 != 3'b000 || jalr_target[1]) state_d = S_HALT;
                  else begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_d = jalr_target; end
               end
               OP_BRANCH: begin
                  if (!br_legal || (br_taken && br_target[1])) state_d = S_HALT;
                  else if (br_taken) pc_d = br_target;
               end
               OP_IMM, OP_OP: begin
                  if (!arith_ok) state_d = S_HALT;
                  else begin rd_we = 1'b1; rd_wdata = alu_result; end
               end
               OP_LOAD: begin
                  pc_d    = pc_q;
                  ea_d    = ea_sum;
                  state_d = ld_legal ? S_MEM : S_HALT;
               end
               OP_STORE: begin
                  pc_d    = pc_q;
                  ea_d    = ea_sum;
                  state_d = st_legal ? S_MEM : S_HALT;
               end
               OP_FENCE: ;
               default:  state_d = S_HALT;
            endcase
            if (state_d == S_HALT) begin
               pc_d  = pc_q;
               rd_we = 1'b0;
            end
         end
         S_MEM: begin
            bus.address = ea_q[31:2];
            if (misaligned) begin
               state_d = S_HALT;
            end else if (opcode == OP_LOAD) begin
               if (!bus.read_capable) state_d = S_HALT;
               else begin
                  rd_we = 1'b1; rd_wdata = ld_data; pc_d = pc_plus4; state_d = S_FETCH;
               end
            end else if (funct3[1:0] == SZ_WORD) begin
               if (!bus.write_capable) state_d = S_HALT;
               else begin
                  bus.write_enable = 1'b1; bus.memory_in = rs2_val;
                  pc_d = pc_plus4; state_d = S_FETCH;
               end
            end else if (bus.read_capable && bus.write_capable) begin
               mdr_d   = bus.memory_out;
               state_d = S_WRITE;
            end else begin
               state_d = S_HALT;
            end
         end
         S_WRITE: begin
            bus.address      = ea_q[31:2];
            bus.write_enable = 1'b1;
            bus.memory_in    = st_merged;
            pc_d             = pc_plus4;
            state_d          = S_FETCH;
         end
         default: begin
            bus.address = addr_q;
            state_d     = S_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         ea_q    <= '0;
         mdr_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ea_q    <= ea_d;
         mdr_q   <= mdr_d;
         addr_q  <= bus.address;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (rd_we && rd != 5'd0) begin
         regs[rd] <= rd_wdata;
      end
   end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: small programs in a model memory, checked
// against hand-computed register values and bus activity.
module tb_rv32i_core;

   logic        clk;
   logic        rst;
   logic [31:0] mem [256];
   logic        clr, ld_en;
   logic [7:0]  ld_a;
   logic [31:0] ld_d;
   int          errors, checks, wr_count;
   logic [31:2] wr_addr;
   logic [31:0] wr_data;

   rv32i_if bus ();

   rv32i_core dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Word 0x80 (byte 0x200) unreadable, word 0x81 (byte 0x204) unwritable.
   assign bus.memory_out    = mem[bus.address[9:2]];
   assign bus.read_capable  = (bus.address[31:10] == '0) && (bus.address[9:2] != 8'h80);
   assign bus.write_capable = (bus.address[31:10] == '0) && (bus.address[9:2] != 8'h81);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
      end else if (ld_en) begin
         mem[ld_a] <= ld_d;
      end else if (bus.write_enable) begin
         mem[bus.address[9:2]] <= bus.memory_in;
      end
   end

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
      return {imm[19:0], rd[4:0], op};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         #1;
         if (bus.write_enable) begin
            wr_count++;
            wr_addr = bus.address;
            wr_data = bus.memory_in;
         end
      end
   endtask

   task automatic hold_reset();
      rst = 1'b1;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic poke(input logic [7:0] a, input logic [31:0] d);
      ld_en = 1'b1;
      ld_a  = a;
      ld_d  = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic release_reset();
      rst      = 1'b0;
      wr_count = 0;
      #1;
   endtask

   initial begin
      errors = 0; checks = 0; wr_count = 0;
      wr_addr = '0; wr_data = '0;
      clr = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
      rst = 1'b1;

      // Reset and basic ALU
      hold_reset();
      poke(8'd0, enc_i(5, 0, 0, 1, 7'b0010011));
      poke(8'd1, enc_i(-7, 1, 0, 2, 7'b0010011));
      #1;
      check("rst_we", {31'd0, bus.write_enable}, 32'd0);
      check("rst_min", bus.memory_in, 32'd0);
      check("rst_addr", {2'b00, bus.address}, 32'd0);
      release_reset();
      check("seq_addr0", {2'b00, bus.address}, 32'd0);
      step(1);
      check("seq_addr1", {2'b00, bus.address}, 32'd0);
      step(1);
      check("seq_addr2", {2'b00, bus.address}, 32'd1);
      step(1);
      check("seq_addr3", {2'b00, bus.address}, 32'd1);
      step(1);
      check("addi_x1", dut.regs[1], 32'd5);
      check("addi_x2", dut.regs[2], 32'hFFFF_FFFE);

      // SW then LW
      hold_reset();
      poke(8'd0, enc_i(5, 0, 0, 1, 7'b0010011));
      poke(8'd1, enc_s(32'h100, 1, 0, 2));
      poke(8'd2, enc_i(32'h100, 0, 2, 3, 7'b0000011));
      release_reset();
      step(12);
      check("sw_count", wr_count, 32'd1);
      check("sw_addr", {2'b00, wr_addr}, 32'h40);
      check("sw_data", wr_data, 32'd5);
      check("lw_x3", dut.regs[3], 32'd5);

      // Byte read-modify-write and byte loads
      hold_reset();
      poke(8'h40, 32'h1122_3344);
      poke(8'd0, enc_i(32'hAB, 0, 0, 1, 7'b0010011));
      poke(8'd1, enc_s(32'h101, 1, 0, 0));
      poke(8'd2, enc_i(32'h101, 0, 0, 4, 7'b0000011));
      poke(8'd3, enc_i(32'h101, 0, 4, 5, 7'b0000011));
      release_reset();
      step(4);
      check("sb_rd_addr", {2'b00, bus.address}, 32'h40);
      check("sb_rd_we", {31'd0, bus.write_enable}, 32'd0);
      step(1);
      check("sb_wr_we", {31'd0, bus.write_enable}, 32'd1);
      check("sb_wr_addr", {2'b00, bus.address}, 32'h40);
      check("sb_wr_data", bus.memory_in, 32'h1122_AB44);
      step(16);
      check("lb_x4", dut.regs[4], 32'hFFFF_FFAB);
      check("lbu_x5", dut.regs[5], 32'h0000_00AB);
      check("sb_mem", mem[8'h40], 32'h1122_AB44);
      check("sb_count", wr_count, 32'd1);

      // Branches and jumps
      hold_reset();
      poke(8'd0, enc_i(-1, 0, 0, 1, 7'b0010011));
      poke(8'd1, enc_i(1, 0, 0, 2, 7'b0010011));
      poke(8'd2, enc_b(8, 0, 0, 0));
      poke(8'd3, enc_i(99, 0, 0, 3, 7'b0010011));
      poke(8'd4, enc_b(8, 2, 1, 4));
      poke(8'd5, enc_i(77, 0, 0, 4, 7'b0010011));
      poke(8'd6, enc_b(8, 2, 1, 6));
      poke(8'd7, enc_i(55, 0, 0, 5, 7'b0010011));
      poke(8'd8, enc_j(8, 6));
      poke(8'd10, enc_j(-4, 7));
      release_reset();
      step(24);
      check("beq_skip", dut.regs[3], 32'd0);
      check("blt_taken", dut.regs[4], 32'd0);
      check("bltu_not", dut.regs[5], 32'd55);
      check("jal_fwd", dut.regs[6], 32'h24);
      check("jal_back", dut.regs[7], 32'h2C);
      check("jal_halt", {2'b00, bus.address}, 32'd9);

      // Register-register ops, LUI, AUIPC, JALR
      hold_reset();
      poke(8'd0, enc_i(-16, 0, 0, 1, 7'b0010011));
      poke(8'd1, enc_i(2, 0, 0, 2, 7'b0010011));
      poke(8'd2, enc_r(32, 2, 1, 5, 3));
      poke(8'd3, enc_r(0, 2, 1, 5, 4));
      poke(8'd4, enc_r(0, 2, 1, 2, 5));
      poke(8'd5, enc_r(0, 2, 1, 3, 6));
      poke(8'd6, enc_r(32, 1, 2, 0, 7));
      poke(8'd7, enc_u(32'h12345, 8, 7'b0110111));
      poke(8'd8, enc_u(1, 10, 7'b0010111));
      poke(8'd9, enc_i(32'h2D, 0, 0, 11, 7'b1100111));
      poke(8'd10, enc_i(1, 0, 0, 12, 7'b0010011));
      release_reset();
      step(26);
      check("sra", dut.regs[3], 32'hFFFF_FFFC);
      check("srl", dut.regs[4], 32'h3FFF_FFFC);
      check("slt", dut.regs[5], 32'd1);
      check("sltu", dut.regs[6], 32'd0);
      check("sub", dut.regs[7], 32'd18);
      check("lui", dut.regs[8], 32'h1234_5000);
      check("auipc", dut.regs[10], 32'h0000_1020);
      check("jalr_link", dut.regs[11], 32'h28);
      check("jalr_skip", dut.regs[12], 32'd0);
      check("jalr_halt", {2'b00, bus.address}, 32'd11);

      // Fault: load from unreadable word
      hold_reset();
      poke(8'd0, enc_i(5, 0, 0, 1, 7'b0010011));
      poke(8'd1, enc_i(32'h200, 0, 2, 3, 7'b0000011));
      release_reset();
      step(10);
      check("flw_addr", {2'b00, bus.address}, 32'h80);
      check("flw_x3", dut.regs[3], 32'd0);
      step(3);
      check("flw_frozen", {2'b00, bus.address}, 32'h80);

      // Fault: store to unwritable word
      hold_reset();
      poke(8'd0, enc_i(5, 0, 0, 1, 7'b0010011));
      poke(8'd1, enc_s(32'h204, 1, 0, 2));
      release_reset();
      step(10);
      check("fsw_addr", {2'b00, bus.address}, 32'h81);
      check("fsw_count", wr_count, 32'd0);
      check("fsw_mem", mem[8'h81], 32'd0);

      // Fault: misaligned halfword load
      hold_reset();
      poke(8'h40, 32'h1122_3344);
      poke(8'd0, enc_i(32'h101, 0, 1, 4, 7'b0000011));
      release_reset();
      step(8);
      check("flh_addr", {2'b00, bus.address}, 32'h40);
      check("flh_x4", dut.regs[4], 32'd0);

      // Fault: ECALL
      hold_reset();
      poke(8'd0, 32'h0000_0073);
      poke(8'd1, enc_i(9, 0, 0, 1, 7'b0010011));
      release_reset();
      step(8);
      check("ecall_addr", {2'b00, bus.address}, 32'd0);
      check("ecall_x1", dut.regs[1], 32'd0);

      // Asynchronous reset during the WRITE cycle of SB
      hold_reset();
      poke(8'h40, 32'h1122_3344);
      poke(8'd0, enc_i(32'hAB, 0, 0, 1, 7'b0010011));
      poke(8'd1, enc_s(32'h101, 1, 0, 0));
      release_reset();
      step(5);
      check("arst_pre_we", {31'd0, bus.write_enable}, 32'd1);
      rst = 1'b1;
      #1;
      check("arst_we", {31'd0, bus.write_enable}, 32'd0);
      check("arst_min", bus.memory_in, 32'd0);
      check("arst_addr", {2'b00, bus.address}, 32'd0);
      @(negedge clk);
      #1;
      check("arst_mem", mem[8'h40], 32'h1122_3344);
      check("arst_x1", dut.regs[1], 32'd0);
      rst = 1'b0;
      #1;
      check("arst_pc", dut.pc_q, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rv32i_core.md
# rv32i_core

Multicycle RV32I processor core (the `cpu` block) that executes from a single word-addressed memory port shared for instructions and data. It sits beside the `memory` block: it drives a word address, write data and a write strobe, and receives read data plus per-address readable/writable flags. One instruction completes every 2–4 cycles.

## Interface
No parameters (reset PC fixed at 0x0000_0000).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `memory_out`  in  32  read data for the word at `address`; combinational (same-cycle) from memory.
- `read_capable`  in  1  high when the word at `address` may be read.
- `write_capable`  in  1  high when the word at `address` may be written.
- `address`  out  [31:2]  word address, byte address = {address, 2'b00}.
- `memory_in`  out  32  write data; 0 whenever `write_enable` is low.
- `write_enable`  out  1  memory writes `memory_in` at `address` on the next rising edge.

## Operation
- Implements RV32I base integer ISA: LUI, AUIPC, JAL, JALR, all branches, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP. FENCE is a no-op. x0 reads 0, writes ignored.
- States: FETCH, EXECUTE, MEM, WRITE, HALT.
- FETCH: `address` = PC[31:2]; instruction register loads `memory_out`. If `read_capable` low or PC[1:0] ≠ 0 → HALT, else → EXECUTE.
- EXECUTE: decode, read rs1/rs2, ALU. ALU/LUI/AUIPC/jumps/branches write rd and update PC (PC+4, branch/JAL target, or JALR (rs1+imm)&~1), → FETCH. Misaligned jump/branch target → HALT. Loads/stores compute EA = rs1 + sext(imm), latch it, → MEM. Illegal opcode/funct, ECALL, EBREAK → HALT.
- MEM: `address` = EA[31:2]. Misaligned EA (halfword on odd, word not 4-aligned) → HALT.
  - Load: requires `read_capable`; extract byte/half by EA[1:0], sign/zero extend, write rd, PC+=4, → FETCH.
  - SW: requires `write_capable`; `write_enable`=1, `memory_in`=rs2, PC+=4, → FETCH.
  - SB/SH: requires `read_capable` and `write_capable`; latch `memory_out`, → WRITE.
  - Any failed requirement → HALT, no write issued.
- WRITE: `address` = EA[31:2]; `memory_in` = latched word with target byte/half replaced by rs2 low bits; `write_enable`=1; PC+=4; → FETCH.
- HALT: absorbing until reset; `write_enable`=0, `address` holds last value.
- Shifts use low 5 bits of shamt; SRA arithmetic; SLT signed, SLTU unsigned; all arithmetic mod 2^32.

## Timing
- Reset: state=FETCH, PC=0, all 32 registers=0, instruction/EA/data latches=0; outputs during reset: `address`=0, `write_enable`=0, `memory_in`=0. Takes effect immediately, including mid-instruction; an in-progress SB/SH is abandoned with no write.
- First fetch on the first rising edge after `rst` deasserts.
- `address`, `write_enable`, `memory_in` are combinational from state and registers (no dependence on `memory_out` except via latched values); memory samples on the rising edge ending the cycle.
- Latency (cycles): ALU/jump/branch 2, load 3, SW 3, SB/SH 4.

## Structure
- Shared package `rv32i_pkg`: opcode constants, funct3/funct7 codes, state enum, ALU op enum, load/store size encodings.
- Sub-module `rv32i_alu` (combinational: op, a, b → result, compare flags). Register file and FSM stay in the core.

## Test plan
- Reset/ALU: mem[0]=ADDI x1,x0,5; mem[1]=ADDI x2,x1,-7 → after 4 cycles x1=5, x2=0xFFFF_FFFE; `address` sequence 0,0,1,1.
- Store/load: SW x1,0x100(x0) then LW x3,0x100(x0) → `write_enable` high exactly one cycle with address 0x40, data 5; x3=5.
- Byte RMW: word 0x100=0x11223344, x1=0xAB, SB x1,0x101(x0) → read cycle then write of 0x1122AB44; LB x4,0x101 → 0xFFFF_FFAB, LBU → 0xAB.
- Branch/jump: BEQ x0,x0,+8 skips next word; JAL x1,-4 sets x1=PC+4 and PC=PC-4; BLT -1 vs 1 taken, BLTU not taken.
- Faults: LW from address with `read_capable`=0, SW to `write_capable`=0, LH at 0x101, ECALL → each enters HALT, no further writes, `address` frozen.
- Async reset asserted during WRITE state → `write_enable` drops immediately, PC=0 on release.
